// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Micro-step sequencer for a small accumulator CPU. The block steps through
// T0 and T1, which fetch the instruction. From T2 on it executes the current
// opcode, then returns to T0. When a HLT executes, the block enters a sticky
// halt state, and only a reset clears it.
//
// The step counter and the halt flag are the only state. All control outputs
// are decoded combinationally from the current step, the opcode and the ALU
// flags. The outputs are gated to zero while reset is asserted, while run is
// low, or while halted.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active low
//   run          in   sequencing enable (0 freezes step and blanks outputs)
//   opcode[7:0]  in   instruction register bits [15:8], valid from T2
//   flag_z       in   ALU zero flag (used by JZ in T2)
//   flag_c       in   ALU carry flag (used by JC in T2)
//   pc_out_en    out  program counter drives the bus
//   ir_out_en    out  instruction register operand drives the bus
//   ram_out_en   out  RAM drives the bus
//   a_out_en     out  A register drives the bus
//   alu_out_en   out  ALU result drives the bus
//   mar_write    out  load memory address register
//   ir_write     out  load instruction register
//   a_write      out  load A register
//   b_write      out  load B register
//   ram_write    out  write RAM
//   flags_write  out  load ALU flags
//   out_write    out  load output register
//   pc_write     out  load program counter (jump)
//   pc_inc       out  increment program counter
//   alu_sub      out  ALU subtract select
//   step[2:0]    out  current micro-step 0..4
//   halted       out  HLT has executed
// -----------------------------------------------------------------------------
module control_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] opcode,
  input  logic       flag_z,
  input  logic       flag_c,
  output logic       pc_out_en,
  output logic       ir_out_en,
  output logic       ram_out_en,
  output logic       a_out_en,
  output logic       alu_out_en,
  output logic       mar_write,
  output logic       ir_write,
  output logic       a_write,
  output logic       b_write,
  output logic       ram_write,
  output logic       flags_write,
  output logic       out_write,
  output logic       pc_write,
  output logic       pc_inc,
  output logic       alu_sub,
  output logic [2:0] step,
  output logic       halted
);

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDA = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h02;
  localparam logic [7:0] OP_SUB = 8'h03;
  localparam logic [7:0] OP_STA = 8'h04;
  localparam logic [7:0] OP_LDI = 8'h05;
  localparam logic [7:0] OP_JMP = 8'h06;
  localparam logic [7:0] OP_JC  = 8'h07;
  localparam logic [7:0] OP_JZ  = 8'h08;
  localparam logic [7:0] OP_OUT = 8'h0E;
  localparam logic [7:0] OP_HLT = 8'h0F;

  localparam int NUM_STEPS = 5;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  // Raw control word before the run/halt/reset gating.
  typedef struct packed {
    logic pc_out_en;
    logic ir_out_en;
    logic ram_out_en;
    logic a_out_en;
    logic alu_out_en;
    logic mar_write;
    logic ir_write;
    logic a_write;
    logic b_write;
    logic ram_write;
    logic flags_write;
    logic out_write;
    logic pc_write;
    logic pc_inc;
    logic alu_sub;
  } ctrl_t;

  step_t                step_reg;
  logic                 halted_reg;
  logic [NUM_STEPS-1:0] step_hot;
  ctrl_t                ctrl_next;
  ctrl_t                ctrl_gated;
  logic                 active;

  // Final micro-step for an opcode. Undefined opcodes behave as NOP.
  function automatic step_t last_step(input logic [7:0] op);
    case (op)
      OP_LDA, OP_STA: last_step = T3;
      OP_ADD, OP_SUB: last_step = T4;
      default:        last_step = T2;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Step counter and halt flag.
  // A low run freezes the sequencer. While halted, run is ignored and the
  // step stays at T2, which is where HLT was decoded.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      step_reg   <= T0;
      halted_reg <= 1'b0;
    end else if (!halted_reg && run) begin
      case (step_reg)
        T0: step_reg <= T1;
        T1: step_reg <= T2;
        T2: begin
          if (opcode == OP_HLT) begin
            halted_reg <= 1'b1;
          end else if (last_step(opcode) == T2) begin
            step_reg <= T0;
          end else begin
            step_reg <= T3;
          end
        end
        // The opcode is re-examined here. If the opcode changed under a
        // multi-step instruction, the block falls back to T0 and does not
        // run into T4 with no defined action.
        T3: step_reg <= (last_step(opcode) == T4) ? T4 : T0;
        T4: step_reg <= T0;
        default: step_reg <= T0;
      endcase
    end
  end

  // One-hot view of the step, which keeps the decoder below flat.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STEPS; gi++) begin : g_step_hot
      assign step_hot[gi] = (step_reg == step_t'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control decode. This block is purely combinational. Flags are looked at
  // only in T2 of JC/JZ, so a jump follows the flag value present in that
  // cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_next = '0;
    if (step_hot[0]) begin
      ctrl_next.pc_out_en = 1'b1;
      ctrl_next.mar_write = 1'b1;
    end else if (step_hot[1]) begin
      ctrl_next.ram_out_en = 1'b1;
      ctrl_next.ir_write   = 1'b1;
      ctrl_next.pc_inc     = 1'b1;
    end else if (step_hot[2]) begin
      case (opcode)
        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
          ctrl_next.ir_out_en = 1'b1;
          ctrl_next.mar_write = 1'b1;
        end
        OP_LDI: begin
          ctrl_next.ir_out_en = 1'b1;
          ctrl_next.a_write   = 1'b1;
        end
        OP_JMP: begin
          ctrl_next.ir_out_en = 1'b1;
          ctrl_next.pc_write  = 1'b1;
        end
        OP_JC: begin
          ctrl_next.ir_out_en = flag_c;
          ctrl_next.pc_write  = flag_c;
        end
        OP_JZ: begin
          ctrl_next.ir_out_en = flag_z;
          ctrl_next.pc_write  = flag_z;
        end
        OP_OUT: begin
          ctrl_next.a_out_en  = 1'b1;
          ctrl_next.out_write = 1'b1;
        end
        // NOP, HLT and undefined opcodes assert nothing in T2.
        default: ctrl_next = '0;
      endcase
    end else if (step_hot[3]) begin
      case (opcode)
        OP_LDA: begin
          ctrl_next.ram_out_en = 1'b1;
          ctrl_next.a_write    = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          ctrl_next.ram_out_en = 1'b1;
          ctrl_next.b_write    = 1'b1;
        end
        OP_STA: begin
          ctrl_next.a_out_en  = 1'b1;
          ctrl_next.ram_write = 1'b1;
        end
        default: ctrl_next = '0;
      endcase
    end else if (step_hot[4]) begin
      if (opcode == OP_ADD || opcode == OP_SUB) begin
        ctrl_next.alu_out_en  = 1'b1;
        ctrl_next.a_write     = 1'b1;
        ctrl_next.flags_write = 1'b1;
        ctrl_next.alu_sub     = (opcode == OP_SUB);
      end
    end
  end

  // Every strobe is blanked during reset, while frozen, and once halted.
  // This prevents a stray bus enable or load strobe in those states.
  assign active     = rst && run && !halted_reg;
  assign ctrl_gated = active ? ctrl_next : '0;

  assign pc_out_en   = ctrl_gated.pc_out_en;
  assign ir_out_en   = ctrl_gated.ir_out_en;
  assign ram_out_en  = ctrl_gated.ram_out_en;
  assign a_out_en    = ctrl_gated.a_out_en;
  assign alu_out_en  = ctrl_gated.alu_out_en;
  assign mar_write   = ctrl_gated.mar_write;
  assign ir_write    = ctrl_gated.ir_write;
  assign a_write     = ctrl_gated.a_write;
  assign b_write     = ctrl_gated.b_write;
  assign ram_write   = ctrl_gated.ram_write;
  assign flags_write = ctrl_gated.flags_write;
  assign out_write   = ctrl_gated.out_write;
  assign pc_write    = ctrl_gated.pc_write;
  assign pc_inc      = ctrl_gated.pc_inc;
  assign alu_sub     = ctrl_gated.alu_sub;

  assign step   = step_reg;
  assign halted = halted_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Directed testbench for control_sequencer. It has three parts:
//   - a table of per-cycle vectors with hand-computed expected outputs
//   - a hand-written halt sequence followed by a reset release
//   - a random opcode run checked against a small step-length model and the
//     bus-exclusivity rules
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  logic       clk;
  logic       rst;
  logic       run;
  logic [7:0] opcode;
  logic       flag_z;
  logic       flag_c;
  logic       pc_out_en, ir_out_en, ram_out_en, a_out_en, alu_out_en;
  logic       mar_write, ir_write, a_write, b_write, ram_write;
  logic       flags_write, out_write, pc_write, pc_inc, alu_sub;
  logic [2:0] step;
  logic       halted;

  control_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .opcode     (opcode),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .pc_out_en  (pc_out_en),
    .ir_out_en  (ir_out_en),
    .ram_out_en (ram_out_en),
    .a_out_en   (a_out_en),
    .alu_out_en (alu_out_en),
    .mar_write  (mar_write),
    .ir_write   (ir_write),
    .a_write    (a_write),
    .b_write    (b_write),
    .ram_write  (ram_write),
    .flags_write(flags_write),
    .out_write  (out_write),
    .pc_write   (pc_write),
    .pc_inc     (pc_inc),
    .alu_sub    (alu_sub),
    .step       (step),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word bit masks, most significant first.
  localparam logic [14:0] PCO  = 15'h4000;
  localparam logic [14:0] IRO  = 15'h2000;
  localparam logic [14:0] RAMO = 15'h1000;
  localparam logic [14:0] AO   = 15'h0800;
  localparam logic [14:0] ALUO = 15'h0400;
  localparam logic [14:0] MARW = 15'h0200;
  localparam logic [14:0] IRW  = 15'h0100;
  localparam logic [14:0] AW   = 15'h0080;
  localparam logic [14:0] BW   = 15'h0040;
  localparam logic [14:0] RAMW = 15'h0020;
  localparam logic [14:0] FLW  = 15'h0010;
  localparam logic [14:0] OUTW = 15'h0008;
  localparam logic [14:0] PCW  = 15'h0004;
  localparam logic [14:0] PCI  = 15'h0002;
  localparam logic [14:0] SUB  = 15'h0001;
  localparam logic [14:0] NONE = 15'h0000;
  localparam logic [14:0] FETCH0 = PCO | MARW;
  localparam logic [14:0] FETCH1 = RAMO | IRW | PCI;

  logic [14:0] ctrl;
  assign ctrl = {pc_out_en, ir_out_en, ram_out_en, a_out_en, alu_out_en,
                 mar_write, ir_write, a_write, b_write, ram_write,
                 flags_write, out_write, pc_write, pc_inc, alu_sub};

  typedef struct {
    logic        rst;
    logic        run;
    logic [7:0]  opcode;
    logic        fz;
    logic        fc;
    logic [2:0]  exp_step;
    logic        exp_halted;
    logic [14:0] exp_ctrl;
  } vec_t;

  localparam int NV = 62;
  vec_t vecs [NV];

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
  endtask

  function automatic vec_t v(input logic r, input logic rn, input logic [7:0] op,
                             input logic fz, input logic fc, input logic [2:0] s,
                             input logic h, input logic [14:0] c);
    vec_t t;
    t.rst = r; t.run = rn; t.opcode = op; t.fz = fz; t.fc = fc;
    t.exp_step = s; t.exp_halted = h; t.exp_ctrl = c;
    return t;
  endfunction

  // Final step of an opcode, written from the instruction-length table.
  function automatic int model_last(input logic [7:0] op);
    if (op == 8'h01 || op == 8'h04) return 3;
    if (op == 8'h02 || op == 8'h03) return 4;
    return 2;
  endfunction

  int          exp_step;
  logic [7:0]  cur_op;
  int          oe_count;

  initial begin
    // rst, run, op, fz, fc, step, halted, ctrl
    vecs[0]  = v(0, 1, 8'h05, 0, 0, 0, 0, NONE);        // reset forces outputs off
    vecs[1]  = v(1, 1, 8'h05, 0, 0, 0, 0, FETCH0);      // LDI
    vecs[2]  = v(1, 1, 8'h05, 0, 0, 1, 0, FETCH1);
    vecs[3]  = v(1, 1, 8'h05, 0, 0, 2, 0, IRO | AW);
    vecs[4]  = v(1, 1, 8'h02, 0, 0, 0, 0, FETCH0);      // ADD
    vecs[5]  = v(1, 1, 8'h02, 0, 0, 1, 0, FETCH1);
    vecs[6]  = v(1, 1, 8'h02, 0, 0, 2, 0, IRO | MARW);
    vecs[7]  = v(1, 1, 8'h02, 0, 0, 3, 0, RAMO | BW);
    vecs[8]  = v(1, 1, 8'h02, 0, 0, 4, 0, ALUO | AW | FLW);
    vecs[9]  = v(1, 1, 8'h03, 0, 0, 0, 0, FETCH0);      // SUB
    vecs[10] = v(1, 1, 8'h03, 0, 0, 1, 0, FETCH1);
    vecs[11] = v(1, 1, 8'h03, 0, 0, 2, 0, IRO | MARW);
    vecs[12] = v(1, 1, 8'h03, 0, 0, 3, 0, RAMO | BW);
    vecs[13] = v(1, 1, 8'h03, 0, 0, 4, 0, ALUO | AW | FLW | SUB);
    vecs[14] = v(1, 1, 8'h08, 0, 0, 0, 0, FETCH0);      // JZ not taken
    vecs[15] = v(1, 1, 8'h08, 0, 0, 1, 0, FETCH1);
    vecs[16] = v(1, 1, 8'h08, 0, 1, 2, 0, NONE);
    vecs[17] = v(1, 1, 8'h08, 1, 0, 0, 0, FETCH0);      // JZ taken
    vecs[18] = v(1, 1, 8'h08, 1, 0, 1, 0, FETCH1);
    vecs[19] = v(1, 1, 8'h08, 1, 0, 2, 0, IRO | PCW);
    vecs[20] = v(1, 1, 8'h07, 0, 1, 0, 0, FETCH0);      // JC not taken
    vecs[21] = v(1, 1, 8'h07, 0, 1, 1, 0, FETCH1);
    vecs[22] = v(1, 1, 8'h07, 1, 0, 2, 0, NONE);
    vecs[23] = v(1, 1, 8'h07, 0, 1, 0, 0, FETCH0);      // JC taken
    vecs[24] = v(1, 1, 8'h07, 0, 1, 1, 0, FETCH1);
    vecs[25] = v(1, 1, 8'h07, 0, 1, 2, 0, IRO | PCW);
    vecs[26] = v(1, 1, 8'h04, 0, 0, 0, 0, FETCH0);      // STA
    vecs[27] = v(1, 1, 8'h04, 0, 0, 1, 0, FETCH1);
    vecs[28] = v(1, 1, 8'h04, 0, 0, 2, 0, IRO | MARW);
    vecs[29] = v(1, 1, 8'h04, 0, 0, 3, 0, AO | RAMW);
    vecs[30] = v(1, 1, 8'h0E, 0, 0, 0, 0, FETCH0);      // OUT
    vecs[31] = v(1, 1, 8'h0E, 0, 0, 1, 0, FETCH1);
    vecs[32] = v(1, 1, 8'h0E, 0, 0, 2, 0, AO | OUTW);
    vecs[33] = v(1, 1, 8'h06, 0, 0, 0, 0, FETCH0);      // JMP
    vecs[34] = v(1, 1, 8'h06, 0, 0, 1, 0, FETCH1);
    vecs[35] = v(1, 1, 8'h06, 0, 0, 2, 0, IRO | PCW);
    vecs[36] = v(1, 1, 8'h55, 1, 1, 0, 0, FETCH0);      // undefined
    vecs[37] = v(1, 1, 8'h55, 1, 1, 1, 0, FETCH1);
    vecs[38] = v(1, 1, 8'h55, 1, 1, 2, 0, NONE);
    vecs[39] = v(1, 1, 8'h00, 0, 0, 0, 0, FETCH0);      // NOP
    vecs[40] = v(1, 1, 8'h00, 0, 0, 1, 0, FETCH1);
    vecs[41] = v(1, 1, 8'h00, 0, 0, 2, 0, NONE);
    vecs[42] = v(1, 1, 8'h01, 0, 0, 0, 0, FETCH0);      // LDA with freeze in T3
    vecs[43] = v(1, 1, 8'h01, 0, 0, 1, 0, FETCH1);
    vecs[44] = v(1, 1, 8'h01, 0, 0, 2, 0, IRO | MARW);
    vecs[45] = v(1, 0, 8'h01, 0, 0, 3, 0, NONE);
    vecs[46] = v(1, 0, 8'h01, 0, 0, 3, 0, NONE);
    vecs[47] = v(1, 0, 8'h01, 0, 0, 3, 0, NONE);
    vecs[48] = v(1, 0, 8'h01, 0, 0, 3, 0, NONE);
    vecs[49] = v(1, 1, 8'h01, 0, 0, 3, 0, RAMO | AW);
    vecs[50] = v(1, 1, 8'h02, 0, 0, 0, 0, FETCH0);      // ADD cut by reset
    vecs[51] = v(1, 1, 8'h02, 0, 0, 1, 0, FETCH1);
    vecs[52] = v(1, 1, 8'h02, 0, 0, 2, 0, IRO | MARW);
    vecs[53] = v(0, 1, 8'h02, 0, 0, 3, 0, NONE);
    vecs[54] = v(1, 1, 8'h02, 0, 0, 0, 0, FETCH0);
    vecs[55] = v(1, 1, 8'h0F, 0, 0, 1, 0, FETCH1);      // HLT
    vecs[56] = v(1, 1, 8'h0F, 0, 0, 2, 0, NONE);
    vecs[57] = v(1, 1, 8'h0F, 0, 0, 2, 1, NONE);
    vecs[58] = v(1, 1, 8'h02, 1, 1, 2, 1, NONE);
    vecs[59] = v(1, 0, 8'h05, 0, 0, 2, 1, NONE);
    vecs[60] = v(0, 1, 8'h05, 0, 0, 2, 1, NONE);
    vecs[61] = v(1, 1, 8'h05, 0, 0, 0, 0, FETCH0);      // back at T0 after reset

    rst = 1'b0; run = 1'b1; opcode = 8'h00; flag_z = 1'b0; flag_c = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; run = vecs[i].run; opcode = vecs[i].opcode;
      flag_z = vecs[i].fz; flag_c = vecs[i].fc;
      #1;
      check($sformatf("vec%0d_step", i), 32'(step), 32'(vecs[i].exp_step));
      check($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].exp_halted));
      check($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].exp_ctrl));
      $display("vec %0d rst=%0b run=%0b op=%02h step=%0d halted=%0b ctrl=%04h",
               i, rst, run, opcode, step, halted, ctrl);
    end

    // Halt held for 12 cycles with run and opcode changing; then a single reset edge.
    opcode = 8'h0F; run = 1'b1;
    @(posedge clk); #2;
    check("hlt_t1", 32'(step), 32'd1);
    @(posedge clk); #2;
    check("hlt_t2", 32'(step), 32'd2);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      opcode = 8'($urandom_range(0, 255));
      run = 1'($urandom_range(0, 1));
      flag_z = 1'($urandom_range(0, 1));
      flag_c = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("halt%0d_halted", k), 32'(halted), 32'd1);
      check($sformatf("halt%0d_step", k), 32'(step), 32'd2);
      check($sformatf("halt%0d_ctrl", k), 32'(ctrl), 32'd0);
      $display("halt %0d run=%0b op=%02h step=%0d halted=%0b ctrl=%04h",
               k, run, opcode, step, halted, ctrl);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; run = 1'b1;
    #1;
    check("hlt_exit_halted", 32'(halted), 32'd0);
    check("hlt_exit_step", 32'(step), 32'd0);

    // Random opcodes, HLT excluded so the run keeps going.
    exp_step = 0;
    cur_op = 8'h00;
    for (int c = 0; c < 1000; c++) begin
      if (exp_step == 0) begin
        cur_op = 8'($urandom_range(0, 255));
        if (cur_op == 8'h0F) cur_op = 8'h42;
      end
      opcode = cur_op;
      flag_z = 1'($urandom_range(0, 1));
      flag_c = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("rnd%0d_step", c), 32'(step), 32'(exp_step));
      oe_count = int'(pc_out_en) + int'(ir_out_en) + int'(ram_out_en)
               + int'(a_out_en) + int'(alu_out_en);
      if (oe_count > 1) check($sformatf("rnd%0d_one_oe", c), 32'(oe_count), 32'd1);
      if (pc_inc && pc_write) check($sformatf("rnd%0d_pc_excl", c), 32'd1, 32'd0);
      if (exp_step == 2 && (cur_op > 8'h08) && cur_op != 8'h0E)
        check($sformatf("rnd%0d_undef_t2", c), 32'(ctrl), 32'd0);
      if (c % 100 == 0)
        $display("rnd %0d op=%02h step=%0d ctrl=%04h", c, opcode, step, ctrl);
      exp_step = (exp_step == model_last(cur_op)) ? 0 : exp_step + 1;
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port run  input  1  sequencing enable; 0 freezes the sequencer.
REQ-004 SHALL have port opcode  input  8  instruction register bits [15:8], valid from step T2.
REQ-005 SHALL have ports flag_z, flag_c  input  1 each  ALU zero and carry flags.
REQ-006 SHALL have bus-driver enables pc_out_en, ir_out_en, ram_out_en, a_out_en, alu_out_en  output  1 each.
REQ-007 SHALL have load strobes mar_write, ir_write, a_write, b_write, ram_write, flags_write, out_write, pc_write  output  1 each.
REQ-008 SHALL have outputs pc_inc  1  PC increment, and alu_sub  1  ALU subtract select.
REQ-009 SHALL have outputs step  output  3  current micro-step (0-4), and halted  output  1  HLT executed.

Function
REQ-010 SHALL hold a micro-step counter T0..T4 plus a halt state; control outputs decoded combinationally from step, opcode and flags.
REQ-011 SHALL decode T0: pc_out_en, mar_write.
REQ-012 SHALL decode T1: ram_out_en, ir_write, pc_inc.
REQ-013 SHALL decode T2 onward per opcode (each op returns to T0 after its last step):
- 0x00 NOP: T2 none; ends T2.
- 0x01 LDA: T2 ir_out_en+mar_write; T3 ram_out_en+a_write; ends T3.
- 0x02 ADD: T2 ir_out_en+mar_write; T3 ram_out_en+b_write; T4 alu_out_en+a_write+flags_write; ends T4.
- 0x03 SUB: as ADD with alu_sub=1 in T4 only.
- 0x04 STA: T2 ir_out_en+mar_write; T3 a_out_en+ram_write; ends T3.
- 0x05 LDI: T2 ir_out_en+a_write; ends T2.
- 0x06 JMP: T2 ir_out_en+pc_write; ends T2.
- 0x07 JC: T2 ir_out_en+pc_write only if flag_c=1, else none; ends T2.
- 0x08 JZ: as JC using flag_z.
- 0x0E OUT: T2 a_out_en+out_write; ends T2.
- 0x0F HLT: T2 none; enters halt state.
- any other opcode: executes as NOP.
REQ-014 SHALL give instruction lengths: 3 cycles (NOP, LDI, JMP, JC, JZ, OUT, undefined), 4 (LDA, STA), 5 (ADD, SUB); HLT reaches halt after 3.
REQ-015 SHALL sample flag_z/flag_c combinationally during T2 of JZ/JC only.
REQ-016 SHALL assert at most one *_out_en in any cycle; pc_inc and pc_write never both high.
REQ-017 SHALL, when run=0, hold step unchanged and force all control outputs to 0; on run=1 resume the same step with its normal decode.
REQ-018 SHALL, in halt state, force all control outputs to 0, hold halted=1, ignore run and opcode; exit only via reset.
REQ-019 SHALL report step as 3'd0..3'd4 matching T0..T4; step holds last value (3'd2) while halted.

Reset
REQ-020 SHALL on rst=0 at a rising clk edge set step=0, halted=0, regardless of run, step, or halt.
REQ-021 SHALL force all control outputs to 0 while rst=0; first cycle after rst=1 with run=1 decodes T0.
REQ-022 SHALL abandon any instruction in progress when reset mid-operation; no partial completion afterwards.

Verification
REQ-023 Reset, run=1, opcode=0x05 -> cycles: T0 pc_out_en+mar_write, T1 ram_out_en+ir_write+pc_inc, T2 ir_out_en+a_write, next cycle step=0.
REQ-024 opcode=0x02 -> 5-cycle sequence per REQ-013, flags_write only in T4, alu_sub=0; repeat with 0x03 -> alu_sub=1 in T4 only.
REQ-025 opcode=0x08 with flag_z=0 -> T2 no pc_write; with flag_z=1 -> T2 ir_out_en+pc_write; both return to T0 next cycle.
REQ-026 opcode=0x01, run=0 during T3 for 4 cycles -> step=3 held, all outputs 0; run=1 -> ram_out_en+a_write, then step=0.
REQ-027 opcode=0x0F -> halted=1 after T2, outputs 0 for 10+ cycles despite run=1 and opcode changes; rst=0 one edge -> halted=0, step=0.
REQ-028 Random opcodes including undefined (0x09-0x0D, 0x10-0xFF) for 1000 cycles -> undefined take 3 cycles with no strobes in T2; REQ-016 never violated.
